// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode unit: FSM state codes, instruction
// field positions and the opcode map.
package fde_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // Instruction word layout: op | immed | flag_en | rd | rs/imm7
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int IMM_BIT  = 11;
  localparam int FLAG_BIT = 10;
  localparam int RD_HI    = 9;
  localparam int RD_LO    = 7;
  localparam int RS_HI    = 6;
  localparam int RS_LO    = 4;
  localparam int IMM7_HI  = 6;
  localparam int IMM7_LO  = 0;
  localparam int IMM7_W   = IMM7_HI - IMM7_LO + 1;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_BR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational split of the instruction register into the fields the
// control unit consumes, including the sign-extended 7-bit immediate.
module instr_decoder
  import fde_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  op,
  output logic        immed,
  output logic        flag_en,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [15:0] imm16
);

  assign op      = ir[OP_HI:OP_LO];
  assign immed   = ir[IMM_BIT];
  assign flag_en = ir[FLAG_BIT];
  assign rd      = ir[RD_HI:RD_LO];
  assign rs      = ir[RS_HI:RS_LO];
  assign imm16   = {{(16 - IMM7_W){ir[IMM7_HI]}}, ir[IMM7_HI:IMM7_LO]};

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: owns PC and IR, fetches over a req/ready handshake,
// holds decoded fields through EXECUTE and applies branch redirects.
module fetch_decode_unit
  import fde_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter int                DATA_W        = 16,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter int                FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  input  logic              exec_done,
  input  logic              pc_sel,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [3:0]        op,
  output logic              immed,
  output logic              flag_en,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [15:0]       imm16,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              fault
);

  localparam int          CNT_W   = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [DATA_W-1:0]  ir_q;
  logic [CNT_W-1:0]   to_cnt_q;
  logic               fault_q;

  logic ld_ir, pc_upd, to_inc, set_fault;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    ld_ir       = 1'b0;
    pc_upd      = 1'b0;
    to_inc      = 1'b0;
    set_fault   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (en) begin
          if (imem_ready) begin
            ld_ir   = 1'b1;
            state_d = ST_DECODE;
          end else begin
            to_inc = 1'b1;
            if (FETCH_TIMEOUT > 0 && to_cnt_q == TO_LAST) begin
              set_fault = 1'b1;
              state_d   = ST_HALT;
            end
          end
        end
      end
      ST_DECODE: begin
        instr_valid = 1'b1;
        if (en) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        instr_valid = 1'b1;
        if (en && exec_done) begin
          pc_upd  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_ir)     ir_q     <= imem_rdata;
      if (ld_ir)     to_cnt_q <= '0;
      else if (to_inc) to_cnt_q <= to_cnt_q + CNT_W'(1);
      if (set_fault) fault_q  <= 1'b1;
      if (pc_upd)    pc_q     <= pc_sel ? branch_target : pc_q + ADDR_W'(1);
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign fault     = fault_q;

  instr_decoder u_decoder (
    .ir      (ir_q[15:0]),
    .op      (op),
    .immed   (immed),
    .flag_en (flag_en),
    .rd      (rd),
    .rs      (rs),
    .imm16   (imm16)
  );

endmodule
